bram_tdp_be: RTL

- Parametrised true-dual-port block RAM with per-lane byte-write enables.
- Adds a selectable read-during-write mode, an optional output register stage, same-address collision detection, and a hardware clear state machine.
- Successor to the fixed 72x1024 dual-port RAM in the yarvi memory subsystem.
- Instruction fetch uses port A; load/store uses port B.

---
 rtl/bram_tdp_be.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bram_tdp_be.sv
// bram_tdp_be: true-dual-port block RAM with per-lane byte-write enables.
//
// Both ports share one clock. After reset (or an init request) a clear
// state machine writes INIT_VALUE to every word, one word per cycle, and
// only then raises ready. In RUN each port accepts one access per cycle.
// Every accepted access returns read data and a valid strobe 1+OUT_REG
// cycles later.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high; clears control and pipeline, not memory
//   init         request a memory clear (honoured only in RUN)
//   ready        high in RUN; accesses are accepted only while high
//   x_en         port access enable (x = a, b)
//   x_wr         write qualifier for the access
//   x_be         per-lane write enables, LANES bits
//   x_addr       word address
//   x_din        write data
//   x_dout       read data; holds its last value while x_valid is low
//   x_valid      x_dout carries the result of an accepted access
//   collision    one-cycle pulse, aligned with valid, on a same-address
//                conflict where at least one port writes
module bram_tdp_be #(
  parameter int              DATA        = 72,
  parameter int              ADDR        = 10,
  parameter int              LANE        = 8,
  parameter int              WRITE_FIRST = 0,
  parameter int              OUT_REG     = 0,
  parameter logic [DATA-1:0] INIT_VALUE  = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   init,
  output logic                   ready,
  input  logic                   a_en,
  input  logic                   a_wr,
  input  logic [DATA/LANE-1:0]   a_be,
  input  logic [ADDR-1:0]        a_addr,
  input  logic [DATA-1:0]        a_din,
  output logic [DATA-1:0]        a_dout,
  output logic                   a_valid,
  input  logic                   b_en,
  input  logic                   b_wr,
  input  logic [DATA/LANE-1:0]   b_be,
  input  logic [ADDR-1:0]        b_addr,
  input  logic [DATA-1:0]        b_din,
  output logic [DATA-1:0]        b_dout,
  output logic                   b_valid,
  output logic                   collision
);

  localparam int LANES = DATA / LANE;
  localparam logic [ADDR-1:0] CNT_LAST = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state, state_nxt;
  logic [ADDR-1:0] cnt, cnt_nxt;

  logic [DATA-1:0] mem [2**ADDR];

  // Replace the lanes of old_w selected by be with the matching lanes of new_w.
  function automatic logic [DATA-1:0] lane_merge(input logic [DATA-1:0] old_w,
                                                 input logic [DATA-1:0] new_w,
                                                 input logic [LANES-1:0] be);
    logic [DATA-1:0] r;
    r = old_w;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) r[i*LANE +: LANE] = new_w[i*LANE +: LANE];
    end
    return r;
  endfunction

  // Clear state machine
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (init) begin
          state_nxt = S_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign ready = (state == S_RUN);

  logic            a_acc, b_acc, a_we, b_we, same_addr, coll;
  logic [LANES-1:0] a_be_eff, b_be_eff;
  logic [DATA-1:0] a_old, b_old, a_final, b_final, a_rd, b_rd;

  assign a_acc     = ready & a_en;
  assign b_acc     = ready & b_en;
  assign a_we      = a_acc & a_wr;
  assign b_we      = b_acc & b_wr;
  assign same_addr = (a_addr == b_addr);
  assign coll      = a_acc & b_acc & same_addr & (a_we | b_we);

  assign a_be_eff  = a_we ? a_be : '0;
  assign b_be_eff  = b_we ? b_be : '0;

  assign a_old     = mem[a_addr];
  assign b_old     = mem[b_addr];

  // Final word at each port's address: A's lanes first, then B's, so B wins
  // on lanes both ports enable when they target the same word.
  assign a_final = lane_merge(lane_merge(a_old, a_din, a_be_eff),
                              b_din, same_addr ? b_be_eff : '0);
  assign b_final = lane_merge(lane_merge(b_old, a_din, same_addr ? a_be_eff : '0),
                              b_din, b_be_eff);

  // A reading port never sees a same-cycle write; only a writing port in
  // write-first mode returns the merged word.
  assign a_rd = (WRITE_FIRST != 0 && a_we) ? a_final : a_old;
  assign b_rd = (WRITE_FIRST != 0 && b_we) ? b_final : b_old;

  // Array update; the clear owns the array while in INIT, where no port
  // access can be accepted.
  always_ff @(posedge clock) begin
    if (state == S_INIT) begin
      mem[cnt] <= INIT_VALUE;
    end else begin
      if (a_we) mem[a_addr] <= a_final;
      if (b_we) mem[b_addr] <= b_final;
    end
  end

  // Stage p0: first read-data register
  logic [DATA-1:0] dout_a_p0, dout_b_p0;
  logic            vld_a_p0, vld_b_p0, col_p0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_a_p0 <= '0;
      dout_b_p0 <= '0;
      vld_a_p0  <= 1'b0;
      vld_b_p0  <= 1'b0;
      col_p0    <= 1'b0;
    end else begin
      vld_a_p0 <= a_acc;
      vld_b_p0 <= b_acc;
      col_p0   <= coll;
      if (a_acc) dout_a_p0 <= a_rd;
      if (b_acc) dout_b_p0 <= b_rd;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      // Stage p1: optional output register
      logic [DATA-1:0] dout_a_p1, dout_b_p1;
      logic            vld_a_p1, vld_b_p1, col_p1;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          dout_a_p1 <= '0;
          dout_b_p1 <= '0;
          vld_a_p1  <= 1'b0;
          vld_b_p1  <= 1'b0;
          col_p1    <= 1'b0;
        end else begin
          vld_a_p1 <= vld_a_p0;
          vld_b_p1 <= vld_b_p0;
          col_p1   <= col_p0;
          if (vld_a_p0) dout_a_p1 <= dout_a_p0;
          if (vld_b_p0) dout_b_p1 <= dout_b_p0;
        end
      end

      assign a_dout    = dout_a_p1;
      assign b_dout    = dout_b_p1;
      assign a_valid   = vld_a_p1;
      assign b_valid   = vld_b_p1;
      assign collision = col_p1;
    end else begin : g_no_out_reg
      assign a_dout    = dout_a_p0;
      assign b_dout    = dout_b_p0;
      assign a_valid   = vld_a_p0;
      assign b_valid   = vld_b_p0;
      assign collision = col_p0;
    end
  endgenerate

endmodule
